// File: rtl/ram_msg_reader.sv
// Reads a byte message from a synchronous-style RAM and packs it into
// big-endian 32-bit words presented over a valid/ready handshake.
module ram_msg_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH:0]   msgLen,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  chipSel,
  output logic                  outEn,
  output logic                  wriEn,
  input  logic [DATA_WIDTH-1:0] ramData,
  output logic [31:0]           wordData,
  output logic [2:0]            wordBytes,
  output logic                  wordLast,
  output logic                  wordValid,
  input  logic                  wordReady,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EMIT, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH:0]   len_reg;
  logic [ADDR_WIDTH:0]   idx_reg;
  logic [ADDR_WIDTH:0]   idx_inc;
  logic [2:0]            cnt_reg;
  logic [31:0]           word_reg;
  logic                  all_sent;

  assign idx_inc  = idx_reg + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign all_sent = (idx_reg == len_reg);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (msgLen == '0) ? DONE : FETCH;
      FETCH:   state_next = CAPTURE;
      CAPTURE: state_next = (cnt_reg == 3'd3 || idx_inc == len_reg) ? EMIT : FETCH;
      EMIT:    if (wordReady) state_next = all_sent ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latched request, byte index, and the word being assembled.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      base_reg <= '0;
      len_reg  <= '0;
      idx_reg  <= '0;
      cnt_reg  <= '0;
      word_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg <= baseAddr;
            len_reg  <= msgLen;
            idx_reg  <= '0;
            cnt_reg  <= '0;
            word_reg <= '0;
          end
        end
        CAPTURE: begin
          case (cnt_reg[1:0])
            2'd0:    word_reg[31:24] <= ramData;
            2'd1:    word_reg[23:16] <= ramData;
            2'd2:    word_reg[15:8]  <= ramData;
            default: word_reg[7:0]   <= ramData;
          endcase
          cnt_reg <= cnt_reg + 3'd1;
          idx_reg <= idx_inc;
        end
        EMIT: begin
          if (wordReady) begin
            word_reg <= '0;
            cnt_reg  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wriEn     = 1'b0;
  assign wordData  = word_reg;
  assign wordBytes = cnt_reg;

  always_comb begin
    chipSel   = 1'b0;
    outEn     = 1'b0;
    addr      = '0;
    wordValid = 1'b0;
    wordLast  = 1'b0;
    busy      = (state_reg != IDLE);
    done      = 1'b0;
    case (state_reg)
      FETCH, CAPTURE: begin
        chipSel = 1'b1;
        outEn   = 1'b1;
        // Address arithmetic is ADDR_WIDTH wide, so it wraps naturally.
        addr    = base_reg + idx_reg[ADDR_WIDTH-1:0];
      end
      EMIT: begin
        wordValid = 1'b1;
        wordLast  = all_sent;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_msg_reader.sv
// Directed bench for ram_msg_reader: RAM holds mem[k]=k, outputs sampled on negedge.
module tb_ram_msg_reader;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  baseAddr = '0;
  logic [10:0] msgLen = '0;
  logic [9:0]  addr;
  logic        chipSel, outEn, wriEn;
  logic [7:0]  ramData;
  logic [31:0] wordData;
  logic [2:0]  wordBytes;
  logic        wordLast, wordValid;
  logic        wordReady = 1'b1;
  logic        busy, done;

  int total = 0;
  int bad = 0;
  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  assign ramData = (chipSel && outEn) ? mem[addr] : 8'h00;

  ram_msg_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
    .clk(clk), .resetN(resetN), .start(start), .baseAddr(baseAddr), .msgLen(msgLen),
    .addr(addr), .chipSel(chipSel), .outEn(outEn), .wriEn(wriEn), .ramData(ramData),
    .wordData(wordData), .wordBytes(wordBytes), .wordLast(wordLast),
    .wordValid(wordValid), .wordReady(wordReady), .busy(busy), .done(done)
  );

  // Returns after the posedge that samples start (edge 0), i.e. inside cycle 1.
  task automatic do_start(input logic [9:0] b, input logic [10:0] l);
    @(negedge clk);
    baseAddr = b;
    msgLen   = l;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges until wordValid is seen; returns limit on timeout.
  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (wordValid !== 1'b1 && cyc < limit);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 60);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_timeout busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (addr !== 10'h0) begin bad++; $display("FAIL reset_addr got %h need 000", addr); end
    total++; if (wordData !== 32'h0) begin bad++; $display("FAIL reset_data got %h need 0", wordData); end
    total++; if ({chipSel, outEn, wriEn, wordValid, wordLast, busy, done, wordBytes} !== 10'b0) begin
      bad++; $display("FAIL reset_ctrl got %b need 0", {chipSel, outEn, wriEn, wordValid, wordLast, busy, done, wordBytes});
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc;
    wordReady = 1'b1;
    do_start(10'h000, 11'd5);
    wait_valid(40, cyc);
    total++; if (cyc !== 9) begin bad++; $display("FAIL basic_latency got %0d need 9", cyc); end
    total++; if (wordData !== 32'h00010203) begin bad++; $display("FAIL basic_w0 got %h need 00010203", wordData); end
    total++; if (wordBytes !== 3'd4 || wordLast !== 1'b0) begin
      bad++; $display("FAIL basic_w0_meta bytes=%0d last=%b need 4/0", wordBytes, wordLast);
    end
    total++; if (chipSel !== 1'b0 || wriEn !== 1'b0) begin bad++; $display("FAIL basic_emit_cs cs=%b we=%b need 0/0", chipSel, wriEn); end
    @(posedge clk);
    wait_valid(40, cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL basic_w1_latency got %0d need 3", cyc); end
    total++; if (wordData !== 32'h04000000) begin bad++; $display("FAIL basic_w1 got %h need 04000000", wordData); end
    total++; if (wordBytes !== 3'd1 || wordLast !== 1'b1) begin
      bad++; $display("FAIL basic_w1_meta bytes=%0d last=%b need 1/1", wordBytes, wordLast);
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b1 || wordValid !== 1'b0) begin
      bad++; $display("FAIL basic_done done=%b busy=%b valid=%b need 1/1/0", done, busy, wordValid);
    end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_after done=%b busy=%b need 0/0", done, busy); end
  endtask

  task automatic test_wrap;
    logic [9:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    wordReady = 1'b1;
    do_start(10'h3FE, 11'd4);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c < 9 && (c % 2) == 1) begin
        total++;
        if (addr !== exp_a[c/2] || chipSel !== 1'b1 || outEn !== 1'b1) begin
          bad++; $display("FAIL wrap_addr%0d got %h cs=%b need %h cs=1", c/2, addr, chipSel, exp_a[c/2]);
        end
      end
    end
    total++; if (wordValid !== 1'b1 || wordData !== 32'hFEFF0001 || wordLast !== 1'b1) begin
      bad++; $display("FAIL wrap_word valid=%b data=%h last=%b need 1/feff0001/1", wordValid, wordData, wordLast);
    end
    wait_idle("wrap");
  endtask

  task automatic test_stall;
    int cyc;
    wordReady = 1'b0;
    do_start(10'h000, 11'd8);
    wait_valid(40, cyc);
    total++; if (cyc !== 9 || wordData !== 32'h00010203) begin
      bad++; $display("FAIL stall_w0 cyc=%0d data=%h need 9/00010203", cyc, wordData);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (wordValid !== 1'b1 || wordData !== 32'h00010203 || chipSel !== 1'b0 || wordBytes !== 3'd4) begin
        bad++; $display("FAIL stall_hold%0d valid=%b data=%h cs=%b need 1/00010203/0", i, wordValid, wordData, chipSel);
      end
    end
    wordReady = 1'b1;
    @(posedge clk);
    wait_valid(40, cyc);
    total++; if (cyc !== 9) begin bad++; $display("FAIL stall_w1_latency got %0d need 9", cyc); end
    total++; if (wordData !== 32'h04050607 || wordLast !== 1'b1 || wordBytes !== 3'd4) begin
      bad++; $display("FAIL stall_w1 data=%h last=%b bytes=%0d need 04050607/1/4", wordData, wordLast, wordBytes);
    end
    wait_idle("stall");
  endtask

  task automatic test_zero;
    wordReady = 1'b1;
    do_start(10'h055, 11'd0);
    @(negedge clk);
    total++; if (busy !== 1'b1 || done !== 1'b1 || wordValid !== 1'b0 || chipSel !== 1'b0) begin
      bad++; $display("FAIL zero_c1 busy=%b done=%b valid=%b cs=%b need 1/1/0/0", busy, done, wordValid, chipSel);
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || wordValid !== 1'b0) begin
      bad++; $display("FAIL zero_c2 busy=%b done=%b valid=%b need 0/0/0", busy, done, wordValid);
    end
  endtask

  task automatic test_start_ignored;
    wordReady = 1'b1;
    do_start(10'h010, 11'd4);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 3) begin
        start = 1'b1; baseAddr = 10'h200; msgLen = 11'd1;
      end else begin
        start = 1'b0;
      end
      if (c < 9 && (c % 2) == 1) begin
        total++;
        if (addr !== 10'h010 + 10'(c/2)) begin
          bad++; $display("FAIL ign_addr%0d got %h need %h", c/2, addr, 10'h010 + 10'(c/2));
        end
      end
    end
    total++; if (wordValid !== 1'b1 || wordData !== 32'h10111213 || wordLast !== 1'b1) begin
      bad++; $display("FAIL ign_word valid=%b data=%h last=%b need 1/10111213/1", wordValid, wordData, wordLast);
    end
    wait_idle("ignored");
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic seen;
    wordReady = 1'b1;
    do_start(10'h000, 11'd4);
    repeat (6) @(negedge clk);
    resetN = 1'b0;
    #1;
    total++; if ({addr, wordData, wordBytes} !== 45'b0 || {chipSel, outEn, wordValid, busy, done} !== 5'b0) begin
      bad++; $display("FAIL mid_reset addr=%h data=%h bytes=%0d cs=%b busy=%b need all 0", addr, wordData, wordBytes, chipSel, busy);
    end
    @(negedge clk);
    resetN = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (wordValid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_abandon activity=%b need 0", seen); end
    do_start(10'h000, 11'd4);
    wait_valid(40, cyc);
    total++; if (cyc !== 9 || wordData !== 32'h00010203 || wordBytes !== 3'd4 || wordLast !== 1'b1) begin
      bad++; $display("FAIL mid_restart cyc=%0d data=%h bytes=%0d last=%b need 9/00010203/4/1", cyc, wordData, wordBytes, wordLast);
    end
    wait_idle("restart");
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = k[7:0];
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_zero;
    test_start_ignored;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
